// File: rtl/gesture_pkg.sv
// Shared gesture-classifier types and sizes used by the FC layers and the argmax reader.
package gesture_pkg;

    localparam int unsigned N_CLASS = 5;
    localparam int unsigned DATA_W  = 8;

    typedef enum logic [2:0] {
        G_SWIPE_LEFT  = 3'd0,
        G_SWIPE_RIGHT = 3'd1,
        G_SWIPE_UP    = 3'd2,
        G_SWIPE_DOWN  = 3'd3,
        G_NONE        = 3'd4
    } gesture_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_HOLD
    } state_t;

endpackage

// File: rtl/argmax_tracker.sv
// Running best / runner-up tracker over a stream of signed logits.
// Exposes the post-update values so the caller can register a result on the last sample's edge.
module argmax_tracker #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     smp_valid,
    input  logic                     smp_first,
    input  logic [IDX_W-1:0]         smp_idx,
    input  logic signed [DATA_W-1:0] smp_data,
    output logic signed [DATA_W-1:0] best_c,
    output logic [IDX_W-1:0]         best_idx_c,
    output logic [DATA_W:0]          margin_c
);

    localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] best_q, second_q, best_d, second_d;
    logic [IDX_W-1:0]         idx_q, idx_d;

    // Strict greater-than keeps the lowest index on ties and pulls second up to best.
    always_comb begin
        best_d   = best_q;
        second_d = second_q;
        idx_d    = idx_q;
        if (smp_valid) begin
            if (smp_first) begin
                best_d   = smp_data;
                idx_d    = '0;
                second_d = MIN_VAL;
            end else if (smp_data > best_q) begin
                second_d = best_q;
                best_d   = smp_data;
                idx_d    = smp_idx;
            end else if (smp_data > second_q) begin
                second_d = smp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            best_q   <= '0;
            second_q <= '0;
            idx_q    <= '0;
        end else begin
            best_q   <= best_d;
            second_q <= second_d;
            idx_q    <= idx_d;
        end
    end

    assign best_c     = best_d;
    assign best_idx_c = idx_d;
    assign margin_c   = {best_d[DATA_W-1], best_d} - {second_d[DATA_W-1], second_d};

endmodule

// File: rtl/fc2_argmax_reader.sv
// Reads the FC2 output logits over BRAM port B and reports argmax class, score and top-two margin
// on a valid/ready handshake.
module fc2_argmax_reader #(
    parameter int unsigned DATA_W  = gesture_pkg::DATA_W,
    parameter int unsigned N_CLASS = gesture_pkg::N_CLASS,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       bram_en,
    output logic [$clog2(N_CLASS)-1:0] bram_addr,
    input  logic [DATA_W-1:0]          bram_dout,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(N_CLASS)-1:0] res_class,
    output logic [DATA_W-1:0]          res_score,
    output logic [DATA_W:0]            res_margin
);
    import gesture_pkg::*;

    localparam int unsigned AW       = $clog2(N_CLASS);
    localparam logic [AW-1:0] LAST   = AW'(N_CLASS - 1);

    state_t state, state_d;

    logic          busy_d, en_d, valid_d, load_res;
    logic [AW-1:0] addr_d;

    logic          dl_vld [RD_LAT];
    logic [AW-1:0] dl_idx [RD_LAT];
    logic          smp_vld;
    logic [AW-1:0] smp_idx;

    logic signed [DATA_W-1:0] best_c;
    logic [AW-1:0]            best_idx_c;
    logic [DATA_W:0]          margin_c;

    assign smp_vld = dl_vld[RD_LAT-1];
    assign smp_idx = dl_idx[RD_LAT-1];

    argmax_tracker #(
        .DATA_W (DATA_W),
        .IDX_W  (AW)
    ) u_tracker (
        .clk        (clk),
        .reset      (reset),
        .smp_valid  (smp_vld),
        .smp_first  (smp_idx == '0),
        .smp_idx    (smp_idx),
        .smp_data   (bram_dout),
        .best_c     (best_c),
        .best_idx_c (best_idx_c),
        .margin_c   (margin_c)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d  = state;
        busy_d   = busy;
        en_d     = 1'b0;
        addr_d   = bram_addr;
        valid_d  = res_valid;
        load_res = 1'b0;
        case (state)
            S_IDLE: begin
                addr_d = '0;
                if (start) begin
                    state_d = S_READ;
                    busy_d  = 1'b1;
                    en_d    = 1'b1;
                end
            end
            S_READ: begin
                if (bram_addr == LAST) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                end else begin
                    en_d   = 1'b1;
                    addr_d = bram_addr + AW'(1);
                end
            end
            S_DRAIN: begin
                if (smp_vld && smp_idx == LAST) begin
                    state_d  = S_HOLD;
                    valid_d  = 1'b1;
                    load_res = 1'b1;
                end
            end
            S_HOLD: begin
                if (res_valid && res_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs, result registers and the read-return tracking line.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            bram_en    <= 1'b0;
            bram_addr  <= '0;
            res_valid  <= 1'b0;
            res_class  <= '0;
            res_score  <= '0;
            res_margin <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                dl_vld[i] <= 1'b0;
                dl_idx[i] <= '0;
            end
        end else begin
            busy      <= busy_d;
            bram_en   <= en_d;
            bram_addr <= addr_d;
            res_valid <= valid_d;
            if (load_res) begin
                res_class  <= best_idx_c;
                res_score  <= best_c;
                res_margin <= margin_c;
            end
            dl_vld[0] <= bram_en;
            dl_idx[0] <= bram_addr;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                dl_vld[i] <= dl_vld[i-1];
                dl_idx[i] <= dl_idx[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fc2_argmax_reader.sv
// Bench for fc2_argmax_reader: two instances (read latency 1 and 3) share stimulus and BRAM contents.
module tb_fc2_argmax_reader;

    localparam int N = 5;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic res_ready = 1'b1;

    logic [1:0] busy_w, en_w, valid_w;
    logic [2:0] addr_w   [2];
    logic [2:0] class_w  [2];
    logic [7:0] dout_w   [2];
    logic [7:0] score_w  [2];
    logic [8:0] margin_w [2];

    int lg [N];
    logic [7:0] p0 = 8'h00;
    logic [7:0] p1 [3] = '{8'h00, 8'h00, 8'h00};

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    bit m_act [2];
    bit m_val [2];
    int m_t   [2];
    int m_cls [2];
    int m_scr [2];
    int m_mrg [2];

    always #5 clk = ~clk;

    fc2_argmax_reader #(.DATA_W(W), .N_CLASS(N), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .busy(busy_w[0]),
        .bram_en(en_w[0]), .bram_addr(addr_w[0]), .bram_dout(dout_w[0]),
        .res_valid(valid_w[0]), .res_ready(res_ready), .res_class(class_w[0]),
        .res_score(score_w[0]), .res_margin(margin_w[0])
    );

    fc2_argmax_reader #(.DATA_W(W), .N_CLASS(N), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .busy(busy_w[1]),
        .bram_en(en_w[1]), .bram_addr(addr_w[1]), .bram_dout(dout_w[1]),
        .res_valid(valid_w[1]), .res_ready(res_ready), .res_class(class_w[1]),
        .res_score(score_w[1]), .res_margin(margin_w[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] rd(input logic [2:0] a);
        return (int'(a) < N) ? 8'(lg[a]) : 8'h00;
    endfunction

    // BRAM port B: output pipeline of RD_LAT registers.
    always @(posedge clk) begin
        if (en_w[0]) p0 <= rd(addr_w[0]);
        if (en_w[1]) p1[0] <= rd(addr_w[1]);
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign dout_w[0] = p0;
    assign dout_w[1] = p1[2];

    // Reference: max with lowest index, runner-up is the max of all other entries.
    function automatic void calc(input int v [N], output int c, output int s, output int m);
        int sec;
        c = 0;
        for (int i = 1; i < N; i++) if (v[i] > v[c]) c = i;
        s = v[c];
        sec = -100000;
        for (int i = 0; i < N; i++) if (i != c && v[i] > sec) sec = v[i];
        m = s - sec;
    endfunction

    // Transaction-level timeline model: t = edges since start was accepted.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_act[d] = 1'b0;
                m_val[d] = 1'b0;
                m_t[d]   = 0;
            end else if (m_val[d] && res_ready) begin
                m_val[d] = 1'b0;
                m_act[d] = 1'b0;
            end else if (!m_act[d]) begin
                if (start) begin
                    m_act[d] = 1'b1;
                    m_t[d]   = 0;
                    calc(lg, m_cls[d], m_scr[d], m_mrg[d]);
                end
            end else begin
                m_t[d] = m_t[d] + 1;
                if (m_t[d] == N + lat(d)) m_val[d] = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                bit exp_en;
                exp_en = m_act[d] && !m_val[d] && (m_t[d] < N);
                chk($sformatf("busy%0d", d), int'(busy_w[d]), int'(m_act[d]));
                chk($sformatf("bram_en%0d", d), int'(en_w[d]), int'(exp_en));
                if (exp_en) chk($sformatf("bram_addr%0d", d), int'(addr_w[d]), m_t[d]);
                chk($sformatf("res_valid%0d", d), int'(valid_w[d]), int'(m_val[d]));
                if (m_val[d]) begin
                    chk($sformatf("res_class%0d", d), int'(class_w[d]), m_cls[d]);
                    chk($sformatf("res_score%0d", d), int'($signed(score_w[d])), m_scr[d]);
                    chk($sformatf("res_margin%0d", d), int'(margin_w[d]), m_mrg[d]);
                end
            end
        end
    end

    task automatic chk_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_busy%0d", tag, d), int'(busy_w[d]), 0);
            chk($sformatf("%s_en%0d", tag, d), int'(en_w[d]), 0);
            chk($sformatf("%s_addr%0d", tag, d), int'(addr_w[d]), 0);
            chk($sformatf("%s_valid%0d", tag, d), int'(valid_w[d]), 0);
            chk($sformatf("%s_class%0d", tag, d), int'(class_w[d]), 0);
            chk($sformatf("%s_score%0d", tag, d), int'(score_w[d]), 0);
            chk($sformatf("%s_margin%0d", tag, d), int'(margin_w[d]), 0);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Start a readout, measure latency to res_valid, compare against hand-computed results.
    task automatic run_case(input string tag, input int v [N], input int ec, input int es, input int em);
        int k, l0, l1;
        int c [2];
        int s [2];
        int m [2];
        lg = v;
        pulse_start();
        k = 0; l0 = -1; l1 = -1;
        while ((l0 < 0 || l1 < 0) && k < 40) begin
            @(negedge clk);
            k++;
            if (valid_w[0] && l0 < 0) begin
                l0 = k; c[0] = int'(class_w[0]); s[0] = int'($signed(score_w[0])); m[0] = int'(margin_w[0]);
                chk({tag, "_model_cls"}, m_cls[0], ec);
                chk({tag, "_model_mrg"}, m_mrg[0], em);
            end
            if (valid_w[1] && l1 < 0) begin
                l1 = k; c[1] = int'(class_w[1]); s[1] = int'($signed(score_w[1])); m[1] = int'(margin_w[1]);
            end
        end
        chk({tag, "_latency1"}, l0, N + 1);
        chk({tag, "_latency3"}, l1, N + 3);
        for (int d = 0; d < 2; d++) begin
            if ((d == 0 ? l0 : l1) >= 0) begin
                chk($sformatf("%s_class%0d", tag, d), c[d], ec);
                chk($sformatf("%s_score%0d", tag, d), s[d], es);
                chk($sformatf("%s_margin%0d", tag, d), m[d], em);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int k;
        lg = '{0, 0, 0, 0, 0};
        repeat (2) @(negedge clk);
        chk_reset("reset");
        reset = 1'b0;
        chk_on = 1'b1;

        run_case("s1",   '{3, -2, 17, 5, -40},        2, 17, 12);
        run_case("tie",  '{9, 9, 4, 9, -1},           0, 9, 0);
        run_case("ext",  '{127, -128, -128, -128, -128}, 0, 127, 255);
        run_case("neg",  '{-128, -128, -128, -128, -128}, 0, -128, 0);

        // Backpressure with ignored start pulses while holding.
        res_ready = 1'b0;
        lg = '{3, -2, 17, 5, -40};
        pulse_start();
        k = 0;
        while (!(valid_w[0] && valid_w[1]) && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("bp_both_valid", int'(valid_w[0] && valid_w[1]), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = (i == 2 || i == 5);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("bp_class%0d", d), int'(class_w[d]), 2);
                chk($sformatf("bp_score%0d", d), int'($signed(score_w[d])), 17);
                chk($sformatf("bp_margin%0d", d), int'(margin_w[d]), 12);
            end
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("bp_release_valid%0d", d), int'(valid_w[d]), 0);
            chk($sformatf("bp_release_busy%0d", d), int'(busy_w[d]), 0);
        end
        repeat (2) @(negedge clk);
        chk("bp_no_queued_start", int'(busy_w[0]), 0);
        run_case("fresh", '{-5, -3, -9, -3, -100}, 1, -3, 0);

        // Reset while reading address 2.
        lg = '{3, -2, 17, 5, -40};
        pulse_start();
        repeat (2) @(negedge clk);
        chk("abort_addr", int'(addr_w[0]), 2);
        reset = 1'b1;
        @(negedge clk);
        chk_reset("abort");
        reset = 1'b0;
        repeat (10) @(negedge clk);
        run_case("ramp", '{0, 1, 2, 3, 4}, 4, 4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
